// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle between an upstream word source and serial_bit_feeder.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             sequence_out;
  logic             bit_valid;
  logic             frame_done;
  logic             busy;

  // Word source / observer side
  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  sequence_out,
    input  bit_valid,
    input  frame_done,
    input  busy
  );

  // Serializer side
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output sequence_out,
    output bit_valid,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the Moore sequence detector: one bit per clock,
// one-word pending buffer behind the shifter, optional idle gap after each word.
module serial_bit_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam bit HAS_GAP = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_full;
  logic             r_seq;
  logic             r_bit_valid;
  logic             r_frame_done;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [GAP_W-1:0] w_gap_cnt_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             w_pend_full_nxt;
  logic             w_seq_nxt;
  logic             w_bit_valid_nxt;
  logic             w_frame_done_nxt;
  logic             w_busy_nxt;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;

  logic             w_ready;
  logic             w_accept;
  logic             w_shift_last;
  logic             w_free;

  // Shifter always emits from its top bit, so LSB-first words are reversed on load.
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] res;
    res = word;
    if (!MSB_FIRST) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        res[i] = word[WIDTH-1-i];
      end
    end
    return res;
  endfunction

  assign w_ready      = !reset && !r_pend_full;
  assign w_accept     = bus.data_valid && w_ready;
  assign w_shift_last = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);
  assign w_free       = (r_state == ST_IDLE)
                     || (w_shift_last && !HAS_GAP)
                     || ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST));

  assign bus.data_ready   = w_ready;
  assign bus.sequence_out = r_seq;
  assign bus.bit_valid    = r_bit_valid;
  assign bus.frame_done   = r_frame_done;
  assign bus.busy         = r_busy;

  // Next-state and next-output decode: pending word has priority at a free edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_pend_nxt       = r_pend;
    w_pend_full_nxt  = r_pend_full;
    w_seq_nxt        = IDLE_LEVEL;
    w_bit_valid_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;
    w_load_word      = '0;

    if (w_free) begin
      if (r_pend_full) begin
        w_load          = 1'b1;
        w_load_word     = r_pend;
        w_pend_full_nxt = 1'b0;
      end else if (w_accept) begin
        w_load      = 1'b1;
        w_load_word = bus.data_in;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      if (w_accept) begin
        w_pend_nxt      = bus.data_in;
        w_pend_full_nxt = 1'b1;
      end
      case (r_state)
        ST_SHIFT: begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt    = r_bit_cnt + CNT_W'(1);
            w_shift_nxt      = r_shift << 1;
            w_seq_nxt        = r_shift[WIDTH-2];
            w_bit_valid_nxt  = 1'b1;
            w_frame_done_nxt = ((r_bit_cnt + CNT_W'(1)) == LAST_BIT);
          end
        end
        ST_GAP: begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (w_load) begin
      w_state_nxt      = ST_SHIFT;
      w_bit_cnt_nxt    = '0;
      w_shift_nxt      = orient(w_load_word);
      w_seq_nxt        = w_shift_nxt[WIDTH-1];
      w_bit_valid_nxt  = 1'b1;
      w_frame_done_nxt = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE) || w_pend_full_nxt;
  end

  // State and output registers; reset discards both held words.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_seq        <= IDLE_LEVEL;
      r_bit_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_full  <= w_pend_full_nxt;
      r_seq        <= w_seq_nxt;
      r_bit_valid  <= w_bit_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: DUT A is MSB-first with no gap,
// DUT B is LSB-first, idle-high, with a 3-cycle gap.
module tb_serial_bit_feeder;

  logic       clk;
  logic       rst;
  logic       vld;
  logic       sel;
  logic [7:0] din;

  logic w_seq, w_bv, w_fd, w_rdy, w_bsy;

  int n_checks = 0;
  int n_err    = 0;

  serial_bit_feeder_if #(.WIDTH(8)) if_a ();
  serial_bit_feeder_if #(.WIDTH(8)) if_b ();

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)
  ) dut_a (
    .clock(clk), .reset(rst), .bus(if_a)
  );

  serial_bit_feeder #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)
  ) dut_b (
    .clock(clk), .reset(rst), .bus(if_b)
  );

  assign if_a.data_in    = din;
  assign if_b.data_in    = din;
  assign if_a.data_valid = vld && !sel;
  assign if_b.data_valid = vld && sel;

  assign w_seq = sel ? if_b.sequence_out : if_a.sequence_out;
  assign w_bv  = sel ? if_b.bit_valid    : if_a.bit_valid;
  assign w_fd  = sel ? if_b.frame_done   : if_a.frame_done;
  assign w_rdy = sel ? if_b.data_ready   : if_a.data_ready;
  assign w_bsy = sel ? if_b.busy         : if_a.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       rst;
    logic       vld;
    logic [7:0] din;
    logic       seq;
    logic       bv;
    logic       fd;
    logic       rdy;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic ad(input logic s, input logic r, input logic v, input logic [7:0] d,
                    input logic eseq, input logic ebv, input logic efd,
                    input logic erdy, input logic ebsy);
    vec_t e;
    e.sel = s; e.rst = r; e.vld = v; e.din = d;
    e.seq = eseq; e.bv = ebv; e.fd = efd; e.rdy = erdy; e.bsy = ebsy;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0]  words [3];
  int          idx;
  logic        acc;
  logic [23:0] rx;
  int          nbits;
  int          nfd;

  initial begin
    rst = 1'b1; vld = 1'b0; sel = 1'b0; din = 8'h00;

    // Each row: inputs held across one rising edge, outputs expected in the following cycle.
    // Reset and first idle cycle
    ad(0,1,0,8'h00, 0,0,0,0,0);
    ad(1,1,0,8'h00, 1,0,0,0,0);
    ad(0,0,0,8'h00, 0,0,0,1,0);
    // A: single 0xB4, MSB first -> 1,0,1,1,0,1,0,0
    ad(0,0,1,8'hB4, 1,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,1,1,1);
    ad(0,0,0,8'h00, 0,0,0,1,0);
    // A: 0xA5 then 0x3C back to back, no gap
    ad(0,0,1,8'hA5, 1,1,0,1,1);
    ad(0,0,1,8'h3C, 0,1,0,0,1);
    ad(0,0,0,8'h00, 1,1,0,0,1);
    ad(0,0,0,8'h00, 0,1,0,0,1);
    ad(0,0,0,8'h00, 0,1,0,0,1);
    ad(0,0,0,8'h00, 1,1,0,0,1);
    ad(0,0,0,8'h00, 0,1,0,0,1);
    ad(0,0,0,8'h00, 1,1,1,0,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 1,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,0,1,1);
    ad(0,0,0,8'h00, 0,1,1,1,1);
    ad(0,0,0,8'h00, 0,0,0,1,0);
    // B: idle level, then single 0xB4 LSB first -> 0,0,1,0,1,1,0,1, gap of 3
    ad(1,0,0,8'h00, 1,0,0,1,0);
    ad(1,0,1,8'hB4, 0,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,1,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,0);
    // B: 0xA5 then 0x3C, gap between and after
    ad(1,0,1,8'hA5, 1,1,0,1,1);
    ad(1,0,1,8'h3C, 0,1,0,0,1);
    ad(1,0,0,8'h00, 1,1,0,0,1);
    ad(1,0,0,8'h00, 0,1,0,0,1);
    ad(1,0,0,8'h00, 0,1,0,0,1);
    ad(1,0,0,8'h00, 1,1,0,0,1);
    ad(1,0,0,8'h00, 0,1,0,0,1);
    ad(1,0,0,8'h00, 1,1,1,0,1);
    ad(1,0,0,8'h00, 1,0,0,0,1);
    ad(1,0,0,8'h00, 1,0,0,0,1);
    ad(1,0,0,8'h00, 1,0,0,0,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 1,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,0,1,1);
    ad(1,0,0,8'h00, 0,1,1,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,1);
    ad(1,0,0,8'h00, 1,0,0,1,0);

    @(negedge clk);
    foreach (tbl[i]) begin
      sel = tbl[i].sel; rst = tbl[i].rst; vld = tbl[i].vld; din = tbl[i].din;
      step();
      chk($sformatf("vec%0d seq", i),   32'(w_seq), 32'(tbl[i].seq));
      chk($sformatf("vec%0d bv", i),    32'(w_bv),  32'(tbl[i].bv));
      chk($sformatf("vec%0d fd", i),    32'(w_fd),  32'(tbl[i].fd));
      chk($sformatf("vec%0d ready", i), 32'(w_rdy), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d busy", i),  32'(w_bsy), 32'(tbl[i].bsy));
    end

    // Backpressure on A: valid held high, junk on data_in whenever ready is low.
    words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h81;
    sel = 1'b0; rst = 1'b0; vld = 1'b1; din = words[0];
    idx = 0; rx = '0; nbits = 0; nfd = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = vld && w_rdy;
      step();
      if (acc) idx++;
      if (w_bv) begin
        rx = {rx[22:0], w_seq};
        nbits++;
      end
      if (w_fd) nfd++;
      if (idx < 3) begin
        vld = 1'b1;
        din = w_rdy ? words[idx] : 8'($urandom);
      end else begin
        vld = 1'b0;
        din = 8'($urandom);
      end
    end
    chk("bp_words_accepted", 32'(idx), 32'd3);
    chk("bp_bit_count", 32'(nbits), 32'd24);
    chk("bp_bit_stream", 32'(rx), 32'h005AC381);
    chk("bp_frame_done_count", 32'(nfd), 32'd3);
    chk("bp_idle_after", 32'(w_bsy), 32'd0);

    // Reset on A during bit 4 of 0xFF with 0x0F pending.
    vld = 1'b1; din = 8'hFF;
    step();
    din = 8'h0F;
    step();
    chk("rst_pend_ready_low", 32'(w_rdy), 32'd0);
    vld = 1'b0; din = 8'h00;
    step(); step(); step();
    chk("rst_pre_bit4_seq", 32'(w_seq), 32'd1);
    chk("rst_pre_bit4_bv", 32'(w_bv), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_at_bv", 32'(w_bv), 32'd0);
    chk("rst_at_busy", 32'(w_bsy), 32'd0);
    chk("rst_at_seq", 32'(w_seq), 32'd0);
    chk("rst_at_fd", 32'(w_fd), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(w_rdy), 32'd1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      step();
      chk($sformatf("rst_after%0d bv", cyc),    32'(w_bv),  32'd0);
      chk($sformatf("rst_after%0d busy", cyc),  32'(w_bsy), 32'd0);
      chk($sformatf("rst_after%0d fd", cyc),    32'(w_fd),  32'd0);
      chk($sformatf("rst_after%0d ready", cyc), 32'(w_rdy), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
